// File: rtl/demo_pkg.sv
// Shared types and constants for the processor SPI capture path.
package demo_pkg;

    typedef enum logic {IDLE, SHIFT} cap_state_t;

    localparam int DEMO_WORD_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head (no fall-through).
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module sync_fifo
    import demo_pkg::*;
#(
    parameter int W     = DEMO_WORD_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rptr <= rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/spi_capture.sv
// Oversampling SPI receiver for the processor's serial port: edge detect,
// MSB-first deserialiser, word FIFO, framing/overflow flags and counters.
//
//  state | meaning
//  IDLE  | chip select inactive; sclk edges ignored
//  SHIFT | frame open; each sclk rise shifts one bit, full words pushed
module spi_capture
    import demo_pkg::*;
#(
    parameter int WORD_W     = DEMO_WORD_W,
    parameter int FIFO_DEPTH = 4,
    parameter bit CS_ACT_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic              cs_in,
    input  logic              sync_in,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [7:0]        word_cnt,
    output logic              frame_err,
    output logic              overflow,
    output logic [3:0]        sync_cnt
);

    localparam int              BW       = $clog2(WORD_W);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WORD_W - 1);

    cap_state_t        state;
    logic [BW-1:0]     bit_cnt;
    // Only the low WORD_W-1 bits are ever needed: the final bit comes straight from mosi_in.
    logic [WORD_W-2:0] sr;
    logic              sclk_q;
    logic              sync_q;
    logic              cs_act;
    logic              sclk_rise;
    logic              push_word;
    logic [WORD_W-1:0] word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              dropped;

    assign cs_act    = CS_ACT_LOW ? !cs_in : cs_in;
    assign sclk_rise = sclk_in && !sclk_q;
    assign push_word = (state == SHIFT) && cs_act && sclk_rise && (bit_cnt == LAST_BIT);
    assign word      = {sr, mosi_in};
    assign accept    = push_word && (!fifo_full || (rd_ready && !fifo_empty));
    assign dropped   = push_word && fifo_full && !rd_ready;
    assign rd_valid  = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            sclk_q    <= 1'b0;
            sync_q    <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            word_cnt  <= '0;
            sync_cnt  <= '0;
        end else begin
            sclk_q    <= sclk_in;
            sync_q    <= sync_in;
            frame_err <= 1'b0;

            if (sync_in && !sync_q) begin
                sync_cnt <= sync_cnt + 4'd1;
            end
            if (accept) begin
                word_cnt <= word_cnt + 8'd1;
            end
            if (dropped) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_act) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // Chip select release wins over a coincident sclk rise.
                    if (!cs_act) begin
                        state     <= IDLE;
                        frame_err <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                        sr        <= '0;
                    end else if (sclk_rise) begin
                        sr      <= {sr[WORD_W-3:0], mosi_in};
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_word),
        .wdata (word),
        .pop   (rd_ready),
        .rdata (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_spi_capture.sv
// Self-checking bench for spi_capture: table of single-word frames plus
// hand sequences for latency, overflow, framing, reset and sync counting.
module tb_spi_capture;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk_in, mosi_in, cs_in, sync_in, rd_ready;
    logic [W-1:0] rd_data;
    logic         rd_valid, frame_err, overflow;
    logic [7:0]   word_cnt;
    logic [3:0]   sync_cnt;

    int           checks   = 0;
    int           failures = 0;
    int           ferr_cycles = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_wcnt;
    logic         exp_ovf;

    typedef struct {
        logic [W-1:0] data;
        int           nbits;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    spi_capture #(.WORD_W(W), .FIFO_DEPTH(DEPTH), .CS_ACT_LOW(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (sclk_in),
        .mosi_in   (mosi_in),
        .cs_in     (cs_in),
        .sync_in   (sync_in),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .word_cnt  (word_cnt),
        .frame_err (frame_err),
        .overflow  (overflow),
        .sync_cnt  (sync_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop monitor: a pop happens at the next edge whenever valid & ready.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none", rd_data);
            end else begin
                check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (!rst && frame_err) ferr_cycles++;
    end

    task automatic do_reset();
        rst = 1'b1; cs_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
        sync_in = 1'b0; rd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        exp_wcnt = 8'd0;
        exp_ovf  = 1'b0;
    endtask

    task automatic frame_start();
        cs_in = 1'b0;
        tick();
    endtask

    task automatic frame_end();
        cs_in = 1'b1;
        tick(); tick();
    endtask

    // Send nbits MSB-first; ready_last raises rd_ready only for the last-bit rise cycle.
    task automatic send_word(input logic [W-1:0] data, input int nbits, input bit ready_last);
        logic [W-1:0] d;
        d = data;
        for (int i = 0; i < nbits; i++) begin
            mosi_in = d[W-1-i];
            sclk_in = 1'b0;
            tick();
            if (i == nbits - 1 && ready_last) rd_ready = 1'b1;
            if (i == W - 1) begin
                if (exp_q.size() < DEPTH || (rd_ready && exp_q.size() > 0)) begin
                    exp_q.push_back(data);
                    exp_wcnt = exp_wcnt + 8'd1;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            sclk_in = 1'b1;
            tick();
            if (ready_last) rd_ready = 1'b0;
        end
        sclk_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        check({name, "_timeout"}, exp_q.size(), 0);
        check({name, "_empty"}, {31'h0, rd_valid}, 0);
    endtask

    initial begin
        int f0;
        logic [W-1:0] a5;

        vecs[0] = '{8'h3C, 8};
        vecs[1] = '{8'h00, 3};
        vecs[2] = '{8'hC3, 8};
        vecs[3] = '{8'h80, 1};
        vecs[4] = '{8'h7E, 8};
        vecs[5] = '{8'hFF, 7};

        // Reset state
        do_reset();
        check("rst_valid", {31'h0, rd_valid}, 0);
        check("rst_data", {24'h0, rd_data}, 0);
        check("rst_wcnt", {24'h0, word_cnt}, 0);
        check("rst_ferr", {31'h0, frame_err}, 0);
        check("rst_ovf", {31'h0, overflow}, 0);
        check("rst_sync", {28'h0, sync_cnt}, 0);

        // 0xA5 with latency check on the last rise
        a5 = 8'hA5;
        frame_start();
        for (int i = 0; i < W; i++) begin
            mosi_in = a5[W-1-i];
            sclk_in = 1'b0;
            tick();
            sclk_in = 1'b1;
            if (i == W - 1) begin
                check("a5_valid_before", {31'h0, rd_valid}, 0);
                exp_q.push_back(a5);
                exp_wcnt = exp_wcnt + 8'd1;
            end
            tick();
        end
        sclk_in = 1'b0;
        check("a5_valid_after", {31'h0, rd_valid}, 1);
        check("a5_data", {24'h0, rd_data}, 32'hA5);
        check("a5_wcnt", {24'h0, word_cnt}, 1);
        frame_end();
        drain("a5");

        // Back-to-back words in one frame, consumer always ready
        f0 = ferr_cycles;
        rd_ready = 1'b1;
        frame_start();
        send_word(8'h12, 8, 1'b0); rd_ready = 1'b1;
        send_word(8'h34, 8, 1'b0); rd_ready = 1'b1;
        send_word(8'h56, 8, 1'b0); rd_ready = 1'b1;
        frame_end();
        drain("b2b");
        check("b2b_ferr", ferr_cycles - f0, 0);
        check("b2b_wcnt", {24'h0, word_cnt}, {24'h0, exp_wcnt});

        // Table of single-word frames, full and partial
        for (int v = 0; v < 6; v++) begin
            f0 = ferr_cycles;
            frame_start();
            send_word(vecs[v].data, vecs[v].nbits, 1'b0);
            frame_end();
            drain("vec");
            check("vec_ferr", ferr_cycles - f0, (vecs[v].nbits != W) ? 1 : 0);
            check("vec_wcnt", {24'h0, word_cnt}, {24'h0, exp_wcnt});
            check("vec_ovf", {31'h0, overflow}, 0);
        end

        // Overflow: five words into a four-deep FIFO
        do_reset();
        frame_start();
        for (int k = 1; k <= 5; k++) send_word(W'(k), 8, 1'b0);
        frame_end();
        check("ovf_flag", {31'h0, overflow}, {31'h0, exp_ovf});
        check("ovf_set", {31'h0, overflow}, 1);
        check("ovf_wcnt", {24'h0, word_cnt}, 4);

        // Partial frame while full: single-cycle frame_err, FIFO untouched
        frame_start();
        send_word(8'hE0, 3, 1'b0);
        cs_in = 1'b1;
        tick();
        check("ferr_pulse_hi", {31'h0, frame_err}, 1);
        tick();
        check("ferr_pulse_lo", {31'h0, frame_err}, 0);
        check("ferr_wcnt", {24'h0, word_cnt}, 4);
        check("ferr_head", {24'h0, rd_data}, 1);
        drain("ovf");
        check("ovf_sticky", {31'h0, overflow}, 1);
        frame_start();
        send_word(8'h3C, 8, 1'b0);
        frame_end();
        check("post_ferr_data", {24'h0, rd_data}, 32'h3C);
        drain("post_ferr");

        // Reset in the middle of a word
        f0 = ferr_cycles;
        frame_start();
        send_word(8'hFF, 5, 1'b0);
        rst = 1'b1; cs_in = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete(); exp_wcnt = 8'd0; exp_ovf = 1'b0;
        tick();
        check("midrst_ferr", ferr_cycles - f0, 0);
        check("midrst_ovf", {31'h0, overflow}, 0);
        frame_start();
        send_word(8'hFF, 8, 1'b0);
        frame_end();
        check("midrst_data", {24'h0, rd_data}, 32'hFF);
        check("midrst_wcnt", {24'h0, word_cnt}, 1);
        check("midrst_ovf2", {31'h0, overflow}, 0);
        drain("midrst");

        // Push and pop together while full
        do_reset();
        frame_start();
        for (int k = 0; k < 4; k++) send_word(W'(8'h11 + k), 8, 1'b0);
        send_word(8'h15, 8, 1'b1);
        frame_end();
        check("pp_wcnt", {24'h0, word_cnt}, 5);
        check("pp_ovf", {31'h0, overflow}, 0);
        check("pp_head", {24'h0, rd_data}, 32'h12);
        drain("pp");

        // Sync strobe counting
        for (int k = 0; k < 3; k++) begin
            sync_in = 1'b1; tick(); tick();
            sync_in = 1'b0; tick();
        end
        check("sync_cnt", {28'h0, sync_cnt}, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
